// File: rtl/period_detector.sv
// Pulse-to-pulse period measurement with lock detection against an expected period.
// Lock after LOCK_CNT consecutive matches; drops on mismatch, timeout, det_en low or reset.
module period_detector #(
    parameter int unsigned LOCK_CNT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_in,
    input  logic [7:0] period_sel,
    input  logic       det_en,
    output logic [7:0] period_meas,
    output logic       meas_valid,
    output logic       lock,
    output logic       err,
    output logic       timeout
);

    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

    localparam logic [3:0] LOCK_MAX = 4'(LOCK_CNT);

    state_t     state;
    logic [7:0] cnt;
    logic [3:0] mcnt;
    logic       match;

    // cnt is never 0 while measuring, but period_sel==0 is excluded explicitly.
    always_comb begin
        match = (period_sel != '0) && (cnt == period_sel);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            mcnt        <= '0;
            period_meas <= '0;
            meas_valid  <= 1'b0;
            lock        <= 1'b0;
            err         <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            err        <= 1'b0;
            timeout    <= 1'b0;
            if (!det_en) begin
                state <= IDLE;
                lock  <= 1'b0;
                cnt   <= '0;
                mcnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt  <= '0;
                        mcnt <= '0;
                        if (en_in) begin
                            state <= ACQUIRE;
                            cnt   <= 8'd1;
                        end
                    end
                    ACQUIRE, LOCKED: begin
                        if (en_in) begin
                            period_meas <= cnt;
                            meas_valid  <= 1'b1;
                            cnt         <= 8'd1;
                            if (match) begin
                                if (mcnt != LOCK_MAX)
                                    mcnt <= mcnt + 4'd1;
                                if (state == ACQUIRE && (mcnt + 4'd1) >= LOCK_MAX) begin
                                    state <= LOCKED;
                                    lock  <= 1'b1;
                                end
                            end else begin
                                mcnt <= '0;
                                err  <= 1'b1;
                                if (state == LOCKED) begin
                                    state <= ACQUIRE;
                                    lock  <= 1'b0;
                                end
                            end
                        end else if (cnt == 8'hFF) begin
                            // A pulse on this same cycle would have taken the branch above.
                            state   <= IDLE;
                            timeout <= 1'b1;
                            lock    <= 1'b0;
                            cnt     <= '0;
                            mcnt    <= '0;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        lock  <= 1'b0;
                        cnt   <= '0;
                        mcnt  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_period_detector.sv
// Bench for period_detector: vector table plus hand-written lock/relock/timeout sequences,
// with expected outputs queued per driven cycle and checked on the falling edge.
module tb_period_detector;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en_in = 1'b0;
    logic [7:0] period_sel = '0;
    logic       det_en = 1'b0;
    logic [7:0] period_meas;
    logic       meas_valid, lock, err, timeout;

    period_detector #(.LOCK_CNT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .en_in      (en_in),
        .period_sel (period_sel),
        .det_en     (det_en),
        .period_meas(period_meas),
        .meas_valid (meas_valid),
        .lock       (lock),
        .err        (err),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] pm;
        logic       mv;
        logic       lk;
        logic       er;
        logic       to;
    } exp_t;

    typedef struct {
        logic       en;
        logic [7:0] sel;
        logic       de;
        logic       r;
        exp_t       exp;
    } vec_t;

    exp_t  sb[$];
    string nq[$];
    int    total = 0;
    int    bad   = 0;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t  e;
            string n;
            e = sb.pop_front();
            n = nq.pop_front();
            total++;
            if ({period_meas, meas_valid, lock, err, timeout} !== e) begin
                bad++;
                $display("FAIL %s t=%0t: got pm=%0d mv=%b lk=%b er=%b to=%b, want pm=%0d mv=%b lk=%b er=%b to=%b",
                         n, $time, period_meas, meas_valid, lock, err, timeout,
                         e.pm, e.mv, e.lk, e.er, e.to);
            end
        end
    end

    function automatic vec_t mk(input logic en, input logic [7:0] sel, input logic de, input logic r,
                                input logic [7:0] pm, input logic mv, input logic lk,
                                input logic er, input logic to);
        vec_t v;
        v.en = en; v.sel = sel; v.de = de; v.r = r;
        v.exp = '{pm: pm, mv: mv, lk: lk, er: er, to: to};
        return v;
    endfunction

    // One clock: drive inputs, let the edge consume them, queue what must appear after it.
    task automatic cyc(input logic en, input logic [7:0] sel, input logic de, input logic r,
                       input logic [7:0] pm, input logic mv, input logic lk,
                       input logic er, input logic to, input string nm);
        en_in = en; period_sel = sel; det_en = de; rst = r;
        @(posedge clk);
        sb.push_back('{pm: pm, mv: mv, lk: lk, er: er, to: to});
        nq.push_back(nm);
        #1;
    endtask

    task automatic gap_pulse(input int gap, input logic [7:0] sel, input logic [7:0] prev_pm,
                             input logic lk_gap, input logic [7:0] pm, input logic lk,
                             input logic er, input string nm);
        for (int i = 1; i < gap; i++)
            cyc(1'b0, sel, 1'b1, 1'b0, prev_pm, 1'b0, lk_gap, 1'b0, 1'b0, {nm, "_gap"});
        cyc(1'b1, sel, 1'b1, 1'b0, pm, 1'b1, lk, er, 1'b0, nm);
    endtask

    // Arm from idle, then four matching 10-cycle periods; lock rises with the 5th pulse.
    task automatic lock_up(input logic [7:0] prev_pm, input string nm);
        cyc(1'b1, 8'd10, 1'b1, 1'b0, prev_pm, 1'b0, 1'b0, 1'b0, 1'b0, {nm, "_arm"});
        for (int k = 2; k <= 5; k++)
            gap_pulse(10, 8'd10, (k == 2) ? prev_pm : 8'd10, 1'b0, 8'd10, (k == 5), 1'b0,
                      $sformatf("%s_p%0d", nm, k));
    endtask

    initial begin
        vec_t tbl[$];

        tbl.push_back(mk(1, 8'd1, 1, 1,  8'd0, 0, 0, 0, 0)); // reset beats en_in/det_en
        tbl.push_back(mk(0, 8'd1, 1, 1,  8'd0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'd1, 1, 0,  8'd0, 0, 0, 0, 0)); // first pulse only arms
        tbl.push_back(mk(1, 8'd1, 1, 0,  8'd1, 1, 0, 0, 0)); // continuous en_in: period 1
        tbl.push_back(mk(1, 8'd1, 1, 0,  8'd1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 8'd1, 1, 0,  8'd1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 8'd1, 1, 0,  8'd1, 1, 1, 0, 0)); // 4th match -> lock
        tbl.push_back(mk(1, 8'd1, 1, 0,  8'd1, 1, 1, 0, 0)); // stays locked
        tbl.push_back(mk(1, 8'd2, 1, 0,  8'd1, 1, 0, 1, 0)); // period_sel changed on pulse
        tbl.push_back(mk(1, 8'd1, 1, 0,  8'd1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 8'd1, 0, 0,  8'd1, 0, 0, 0, 0)); // det_en low: idle, meas held
        tbl.push_back(mk(1, 8'd1, 1, 0,  8'd1, 0, 0, 0, 0)); // re-arm, no measurement
        tbl.push_back(mk(1, 8'd1, 1, 0,  8'd1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 8'd0, 1, 0,  8'd1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'd0, 1, 0,  8'd2, 1, 0, 1, 0)); // period_sel 0 never matches
        tbl.push_back(mk(1, 8'd0, 1, 0,  8'd1, 1, 0, 1, 0));

        for (int i = 0; i < tbl.size(); i++)
            cyc(tbl[i].en, tbl[i].sel, tbl[i].de, tbl[i].r, tbl[i].exp.pm, tbl[i].exp.mv,
                tbl[i].exp.lk, tbl[i].exp.er, tbl[i].exp.to, $sformatf("vec%0d", i));

        // Lock at period 10 from a clean reset
        cyc(1'b0, 8'd10, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_a");
        lock_up(8'd0, "lock10");

        // Short period while locked, then relock after four good periods
        gap_pulse(7, 8'd10, 8'd10, 1'b1, 8'd7, 1'b0, 1'b1, "short7");
        for (int k = 1; k <= 4; k++)
            gap_pulse(10, 8'd10, (k == 1) ? 8'd7 : 8'd10, 1'b0, 8'd10, (k == 4), 1'b0,
                      $sformatf("relock_p%0d", k));

        // det_en low while locked
        cyc(1'b1, 8'd10, 1'b0, 1'b0, 8'd10, 1'b0, 1'b0, 1'b0, 1'b0, "deten_low");
        lock_up(8'd10, "lock_de");

        // Reset while locked discards everything
        cyc(1'b1, 8'd10, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_locked");
        lock_up(8'd0, "lock_rst");

        // Timeout from LOCKED after 255 cycles without a pulse
        for (int i = 0; i < 254; i++)
            cyc(1'b0, 8'd10, 1'b1, 1'b0, 8'd10, 1'b0, 1'b1, 1'b0, 1'b0, "to_wait");
        cyc(1'b0, 8'd10, 1'b1, 1'b0, 8'd10, 1'b0, 1'b0, 1'b0, 1'b1, "timeout");
        cyc(1'b0, 8'd10, 1'b1, 1'b0, 8'd10, 1'b0, 1'b0, 1'b0, 1'b0, "to_once");
        cyc(1'b1, 8'd10, 1'b1, 1'b0, 8'd10, 1'b0, 1'b0, 1'b0, 1'b0, "to_idle_arm");

        // Pulse exactly on the 255th cycle wins over timeout
        gap_pulse(255, 8'd10, 8'd10, 1'b0, 8'd255, 1'b0, 1'b1, "p255");
        cyc(1'b0, 8'd10, 1'b1, 1'b0, 8'd255, 1'b0, 1'b0, 1'b0, 1'b0, "after255");

        @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
